// File: rtl/cp0_regs.sv
// cp0_regs: coprocessor-0 register file plus the M-stage exception/interrupt arbiter.
//
// Holds BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13) and EPC(14). The block
// decides combinationally whether the M-stage instruction takes an exception or an
// interrupt (req) or commits an eret (eret). It supplies the redirect target, and it
// updates the CP0 state on the following clock edge.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   ExcCode_M[4:0]        M-stage exception code, 0 = none
//   valid_M               M stage holds a real instruction (gates interrupts only)
//   pc_M[31:0], bd_M      PC of the M-stage instruction and its delay-slot flag
//   vaddr_M[31:0]         data address of the M-stage load/store
//   eret_M                M-stage instruction is eret
//   hw_int[5:0]           level-sensitive external interrupt lines
//   we, addr[4:0], wdata  mtc0 write port; addr also selects the mfc0 read
//   rdata[31:0]           mfc0 data (combinational, pre-edge register state)
//   req, eret             exception/interrupt taken, eret committed (combinational)
//   target_pc[31:0]       EXC_VECTOR on req, EPC on eret, else 0
module cp0_regs #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter int unsigned COUNT_DIV  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ExcCode_M,
    input  logic        valid_M,
    input  logic [31:0] pc_M,
    input  logic        bd_M,
    input  logic [31:0] vaddr_M,
    input  logic        eret_M,
    input  logic [5:0]  hw_int,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        req,
    output logic        eret,
    output logic [31:0] target_pc
);

    localparam logic [4:0]  REG_BADVADDR = 5'd8;
    localparam logic [4:0]  REG_COUNT    = 5'd9;
    localparam logic [4:0]  REG_COMPARE  = 5'd11;
    localparam logic [4:0]  REG_STATUS   = 5'd12;
    localparam logic [4:0]  REG_CAUSE    = 5'd13;
    localparam logic [4:0]  REG_EPC      = 5'd14;
    localparam logic [4:0]  EXC_ADEL     = 5'd4;
    localparam logic [4:0]  EXC_ADES     = 5'd5;
    localparam logic [31:0] DIV_LAST     = 32'(COUNT_DIV - 1);

    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic        ti_q, ti_d;
    logic [5:0]  ip_hw_q, ip_hw_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [4:0]  exc_q, exc_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] bad_q, bad_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic [31:0] div_q, div_d;

    logic [31:0] status_s;
    logic [31:0] cause_s;
    logic        int_pend_s;
    logic        req_s;
    logic        eret_s;
    logic        count_tick_s;

    assign status_s = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
    assign cause_s  = {bd_q, ti_q, 14'd0, ip_hw_q, ip_sw_q, 1'b0, exc_q, 2'd0};

    // Interrupts need a real instruction to attach EPC to; exceptions do not.
    assign int_pend_s   = valid_M & ie_q & ~exl_q & (|({ip_hw_q, ip_sw_q} & im_q));
    assign req_s        = (ExcCode_M != 5'd0) | int_pend_s;
    assign eret_s       = eret_M & ~req_s;
    assign count_tick_s = (div_q == DIV_LAST);

    assign req       = req_s;
    assign eret      = eret_s;
    assign target_pc = req_s ? EXC_VECTOR : (eret_s ? epc_q : 32'd0);

    // mfc0 read mux; a same-cycle mtc0 is deliberately not forwarded.
    always_comb begin
        rdata = 32'd0;
        case (addr)
            REG_BADVADDR: rdata = bad_q;
            REG_COUNT:    rdata = count_q;
            REG_COMPARE:  rdata = compare_q;
            REG_STATUS:   rdata = status_s;
            REG_CAUSE:    rdata = cause_s;
            REG_EPC:      rdata = epc_q;
            default:      rdata = 32'd0;
        endcase
    end

    // Next-state logic: timer, then exception > eret > mtc0 for the architectural state.
    always_comb begin
        im_d      = im_q;
        exl_d     = exl_q;
        ie_d      = ie_q;
        bd_d      = bd_q;
        ti_d      = ti_q;
        ip_sw_d   = ip_sw_q;
        exc_d     = exc_q;
        epc_d     = epc_q;
        bad_d     = bad_q;
        count_d   = count_q;
        compare_d = compare_q;
        div_d     = div_q;

        // The timer interrupt shares IP7 with hw_int[5].
        ip_hw_d = {hw_int[5] | ti_q, hw_int[4:0]};

        if (count_tick_s) begin
            count_d = count_q + 32'd1;
            div_d   = 32'd0;
            // Timer fires on the edge where Count steps onto Compare.
            if ((count_q + 32'd1) == compare_q) begin
                ti_d = 1'b1;
            end else begin
                ti_d = ti_q;
            end
        end else begin
            div_d = div_q + 32'd1;
        end

        if (req_s) begin
            exc_d = int_pend_s ? 5'd0 : ExcCode_M;
            exl_d = 1'b1;
            // A nested exception keeps the original return point.
            if (!exl_q) begin
                epc_d = bd_M ? (pc_M - 32'd4) : pc_M;
                bd_d  = bd_M;
            end else begin
                epc_d = epc_q;
                bd_d  = bd_q;
            end
            // A misaligned PC means the fault was the fetch, not the data access.
            if (!int_pend_s && ((ExcCode_M == EXC_ADEL) || (ExcCode_M == EXC_ADES))) begin
                bad_d = (pc_M[1:0] != 2'b00) ? pc_M : vaddr_M;
            end else begin
                bad_d = bad_q;
            end
        end else if (eret_s) begin
            // An mtc0 colliding with eret is dropped so EXL has a single writer.
            exl_d = 1'b0;
        end else if (we) begin
            case (addr)
                REG_COUNT: begin
                    count_d = wdata;
                    div_d   = 32'd0;
                end
                REG_COMPARE: begin
                    compare_d = wdata;
                    ti_d      = 1'b0;
                end
                REG_STATUS: begin
                    im_d  = wdata[15:8];
                    exl_d = wdata[1];
                    ie_d  = wdata[0];
                end
                REG_CAUSE: ip_sw_d = wdata[9:8];
                REG_EPC:   epc_d   = wdata;
                default:   epc_d   = epc_q;
            endcase
        end else begin
            exl_d = exl_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            im_q      <= 8'd0;
            exl_q     <= 1'b0;
            ie_q      <= 1'b0;
            bd_q      <= 1'b0;
            ti_q      <= 1'b0;
            ip_hw_q   <= 6'd0;
            ip_sw_q   <= 2'd0;
            exc_q     <= 5'd0;
            epc_q     <= 32'd0;
            bad_q     <= 32'd0;
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            div_q     <= 32'd0;
        end else begin
            im_q      <= im_d;
            exl_q     <= exl_d;
            ie_q      <= ie_d;
            bd_q      <= bd_d;
            ti_q      <= ti_d;
            ip_hw_q   <= ip_hw_d;
            ip_sw_q   <= ip_sw_d;
            exc_q     <= exc_d;
            epc_q     <= epc_d;
            bad_q     <= bad_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            div_q     <= div_d;
        end
    end

endmodule

// File: tb/tb_cp0_regs.sv
// Self-checking bench for cp0_regs: directed scenarios plus a randomized run, all checked
// against a behavioural model of the CP0 state kept in plain variables.
module tb_cp0_regs;

    localparam logic [31:0] VEC = 32'hBFC0_0380;
    localparam int          DIV = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  ExcCode_M;
    logic        valid_M;
    logic [31:0] pc_M;
    logic        bd_M;
    logic [31:0] vaddr_M;
    logic        eret_M;
    logic [5:0]  hw_int;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        req;
    logic        eret;
    logic [31:0] target_pc;

    always #5 clk = ~clk;

    cp0_regs #(.EXC_VECTOR(VEC), .COUNT_DIV(DIV)) dut (
        .clk(clk), .reset(reset), .ExcCode_M(ExcCode_M), .valid_M(valid_M), .pc_M(pc_M),
        .bd_M(bd_M), .vaddr_M(vaddr_M), .eret_M(eret_M), .hw_int(hw_int), .we(we),
        .addr(addr), .wdata(wdata), .rdata(rdata), .req(req), .eret(eret), .target_pc(target_pc)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Behavioural model state
    logic [7:0]  m_im;
    logic        m_exl, m_ie, m_bd, m_ti;
    logic [5:0]  m_iphw;
    logic [1:0]  m_ipsw;
    logic [4:0]  m_exc;
    logic [31:0] m_epc, m_bad, m_count, m_compare;
    int          m_ticks;

    logic        exp_int, exp_req, exp_eret;
    logic [31:0] exp_tpc, exp_rdata;

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_bad;
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return 32'h0040_0000 | (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
            5'd13:   return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(m_iphw) << 10)
                            | (32'(m_ipsw) << 8) | (32'(m_exc) << 2);
            5'd14:   return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_eval();
        exp_int   = valid_M && m_ie && !m_exl && ((({m_iphw, m_ipsw}) & m_im) != 8'd0);
        exp_req   = (ExcCode_M != 5'd0) || exp_int;
        exp_eret  = eret_M && !exp_req;
        exp_tpc   = exp_req ? VEC : (exp_eret ? m_epc : 32'd0);
        exp_rdata = m_read(addr);
    endtask

    task automatic m_commit();
        logic old_ti;
        if (reset) begin
            m_im = 8'd0; m_exl = 1'b0; m_ie = 1'b0; m_bd = 1'b0; m_ti = 1'b0;
            m_iphw = 6'd0; m_ipsw = 2'd0; m_exc = 5'd0; m_epc = 32'd0; m_bad = 32'd0;
            m_count = 32'd0; m_compare = 32'd0; m_ticks = 0;
        end else begin
            m_eval();
            old_ti = m_ti;
            m_iphw = {hw_int[5] | old_ti, hw_int[4:0]};
            m_ticks = m_ticks + 1;
            if (m_ticks == DIV) begin
                m_ticks = 0;
                m_count = m_count + 32'd1;
                if (m_count == m_compare) m_ti = 1'b1;
            end
            if (exp_req) begin
                m_exc = exp_int ? 5'd0 : ExcCode_M;
                if (!m_exl) begin
                    m_epc = bd_M ? pc_M - 32'd4 : pc_M;
                    m_bd  = bd_M;
                end
                m_exl = 1'b1;
                if (!exp_int && (ExcCode_M == 5'd4 || ExcCode_M == 5'd5))
                    m_bad = (pc_M % 4 != 0) ? pc_M : vaddr_M;
            end else if (exp_eret) begin
                m_exl = 1'b0;
            end else if (we) begin
                case (addr)
                    5'd9:  begin m_count = wdata; m_ticks = 0; end
                    5'd11: begin m_compare = wdata; m_ti = 1'b0; end
                    5'd12: begin m_im = wdata[15:8]; m_exl = wdata[1]; m_ie = wdata[0]; end
                    5'd13: m_ipsw = wdata[9:8];
                    5'd14: m_epc = wdata;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic idle();
        reset = 1'b0; ExcCode_M = 5'd0; valid_M = 1'b0; pc_M = 32'd0; bd_M = 1'b0;
        vaddr_M = 32'd0; eret_M = 1'b0; hw_int = 6'd0; we = 1'b0; addr = 5'd0; wdata = 32'd0;
    endtask

    task automatic settle();
        @(negedge clk);
        m_eval();
    endtask

    task automatic advance();
        @(posedge clk);
        m_commit();
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        advance();
        advance();
        reset = 1'b0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        idle();
        we = 1'b1; addr = a; wdata = d;
        advance();
        idle();
    endtask

    task automatic test_reset();
        logic [4:0]  addrs [6] = '{5'd9, 5'd12, 5'd13, 5'd14, 5'd8, 5'd11};
        logic [31:0] wants [6] = '{32'd0, 32'h0040_0000, 32'd0, 32'd0, 32'd0, 32'd0};
        do_reset();
        for (int s = 0; s < 6; s++) begin
            idle();
            addr = addrs[s];
            settle();
            n_vec++;
            if ({req, eret, target_pc, rdata} !== {exp_req, exp_eret, exp_tpc, exp_rdata}) begin
                n_bad++;
                $display("FAIL reset_model: got req=%b eret=%b tpc=%h rd=%h want %b %b %h %h",
                         req, eret, target_pc, rdata, exp_req, exp_eret, exp_tpc, exp_rdata);
            end
            n_vec++;
            if ({req, eret, rdata} !== {1'b0, 1'b0, wants[s]}) begin
                n_bad++;
                $display("FAIL reset_value: reg %0d got rd=%h req=%b want %h req=0",
                         addrs[s], rdata, req, wants[s]);
            end
            advance();
        end
    endtask

    task automatic test_exception();
        logic [31:0] got, want;
        bit chk;
        do_reset();
        for (int s = 0; s < 4; s++) begin
            idle();
            chk = 1'b1;
            case (s)
                0: begin ExcCode_M = 5'd10; valid_M = 1'b1; pc_M = 32'h8000_0010; addr = 5'd14; end
                1: addr = 5'd14;
                2: addr = 5'd13;
                default: addr = 5'd12;
            endcase
            settle();
            n_vec++;
            if ({req, eret, target_pc, rdata} !== {exp_req, exp_eret, exp_tpc, exp_rdata}) begin
                n_bad++;
                $display("FAIL exc_model: got req=%b eret=%b tpc=%h rd=%h want %b %b %h %h",
                         req, eret, target_pc, rdata, exp_req, exp_eret, exp_tpc, exp_rdata);
            end
            case (s)
                0: begin got = {target_pc[31:1], req}; want = {VEC[31:1], 1'b1}; end
                1: begin got = rdata; want = 32'h8000_0010; end
                2: begin got = 32'(rdata[6:2]); want = 32'd10; end
                default: begin got = 32'(rdata[1]); want = 32'd1; end
            endcase
            if (chk) begin
                n_vec++;
                if (got !== want) begin
                    n_bad++;
                    $display("FAIL exc_ri step %0d: got %h want %h", s, got, want);
                end
            end
            advance();
        end
    endtask

    task automatic test_adel_nested();
        logic [31:0] got, want;
        do_reset();
        for (int s = 0; s < 8; s++) begin
            idle();
            case (s)
                0: begin ExcCode_M = 5'd4; valid_M = 1'b1; pc_M = 32'h8000_0102; bd_M = 1'b1;
                         vaddr_M = 32'h1234_5678; end
                1: addr = 5'd14;
                2: addr = 5'd13;
                3: addr = 5'd8;
                4: begin ExcCode_M = 5'd5; valid_M = 1'b1; pc_M = 32'h8000_0200;
                         vaddr_M = 32'hDEAD_BEE0; end
                5: addr = 5'd14;
                6: addr = 5'd13;
                default: addr = 5'd8;
            endcase
            settle();
            n_vec++;
            if ({req, eret, target_pc, rdata} !== {exp_req, exp_eret, exp_tpc, exp_rdata}) begin
                n_bad++;
                $display("FAIL adel_model: got req=%b eret=%b tpc=%h rd=%h want %b %b %h %h",
                         req, eret, target_pc, rdata, exp_req, exp_eret, exp_tpc, exp_rdata);
            end
            case (s)
                0, 4: begin got = {target_pc[31:1], req}; want = {VEC[31:1], 1'b1}; end
                1, 5: begin got = rdata; want = 32'h8000_00FE; end
                2: begin got = 32'(rdata[31]); want = 32'd1; end
                3: begin got = rdata; want = 32'h8000_0102; end
                6: begin got = 32'(rdata[6:2]); want = 32'd5; end
                default: begin got = rdata; want = 32'hDEAD_BEE0; end
            endcase
            n_vec++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL adel_nested step %0d: got %h want %h", s, got, want);
            end
            advance();
        end
    endtask

    task automatic test_interrupt();
        int req_at;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            mtc0(5'd12, 32'h0000_0401);
            req_at = -1;
            for (int k = 0; k < 8 && req_at < 0; k++) begin
                idle();
                hw_int = 6'd1; addr = 5'd13;
                valid_M = (pass == 0) ? 1'b1 : (k >= 4);
                settle();
                n_vec++;
                if ({req, eret, target_pc, rdata} !== {exp_req, exp_eret, exp_tpc, exp_rdata}) begin
                    n_bad++;
                    $display("FAIL int_model: got req=%b eret=%b tpc=%h rd=%h want %b %b %h %h",
                             req, eret, target_pc, rdata, exp_req, exp_eret, exp_tpc, exp_rdata);
                end
                if (req === 1'b1) req_at = k;
                advance();
            end
            n_vec++;
            if (req_at != ((pass == 0) ? 1 : 4)) begin
                n_bad++;
                $display("FAIL int_latency pass %0d: req at cycle %0d want %0d",
                         pass, req_at, (pass == 0) ? 1 : 4);
            end
            idle();
            addr = 5'd13;
            settle();
            n_vec++;
            if ({rdata[10], rdata[6:2]} !== {1'b1, 5'd0}) begin
                n_bad++;
                $display("FAIL int_cause: got IP2=%b exc=%0d want IP2=1 exc=0", rdata[10], rdata[6:2]);
            end
            advance();
        end
    endtask

    task automatic test_timer();
        int ti_at, req_at;
        do_reset();
        mtc0(5'd12, 32'h0000_8001);
        mtc0(5'd11, 32'd5);
        mtc0(5'd9, 32'd0);
        ti_at = -1; req_at = -1;
        for (int i = 0; i < 16; i++) begin
            idle();
            valid_M = 1'b1; addr = 5'd13;
            settle();
            n_vec++;
            if ({req, eret, target_pc, rdata} !== {exp_req, exp_eret, exp_tpc, exp_rdata}) begin
                n_bad++;
                $display("FAIL timer_model: got req=%b eret=%b tpc=%h rd=%h want %b %b %h %h",
                         req, eret, target_pc, rdata, exp_req, exp_eret, exp_tpc, exp_rdata);
            end
            if (rdata[30] === 1'b1 && ti_at < 0) ti_at = i;
            if (req === 1'b1 && req_at < 0) req_at = i;
            advance();
        end
        n_vec++;
        if (ti_at != 10 || req_at != 11) begin
            n_bad++;
            $display("FAIL timer_fire: TI at %0d req at %0d want 10 and 11", ti_at, req_at);
        end
        mtc0(5'd11, 32'd100);
        addr = 5'd13;
        settle();
        n_vec++;
        if (rdata[30] !== 1'b0) begin
            n_bad++;
            $display("FAIL timer_clear: got TI=%b want 0", rdata[30]);
        end
        advance();
    endtask

    task automatic test_count_wrap();
        logic [31:0] wants [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
        do_reset();
        mtc0(5'd9, 32'hFFFF_FFFF);
        for (int s = 0; s < 3; s++) begin
            idle();
            addr = 5'd9;
            settle();
            n_vec++;
            if ({rdata, req} !== {exp_rdata, exp_req} || rdata !== wants[s]) begin
                n_bad++;
                $display("FAIL count_wrap step %0d: got %h want %h", s, rdata, wants[s]);
            end
            advance();
        end
    endtask

    task automatic test_eret();
        logic [31:0] got, want;
        do_reset();
        mtc0(5'd14, 32'h8000_0040);
        mtc0(5'd12, 32'h0000_0002);
        for (int s = 0; s < 3; s++) begin
            idle();
            case (s)
                0: begin eret_M = 1'b1; valid_M = 1'b1; addr = 5'd12; end
                1: addr = 5'd12;
                default: begin eret_M = 1'b1; valid_M = 1'b1; ExcCode_M = 5'd12; end
            endcase
            settle();
            n_vec++;
            if ({req, eret, target_pc, rdata} !== {exp_req, exp_eret, exp_tpc, exp_rdata}) begin
                n_bad++;
                $display("FAIL eret_model: got req=%b eret=%b tpc=%h rd=%h want %b %b %h %h",
                         req, eret, target_pc, rdata, exp_req, exp_eret, exp_tpc, exp_rdata);
            end
            case (s)
                0: begin got = target_pc ^ {30'd0, req, eret}; want = 32'h8000_0041; end
                1: begin got = rdata; want = 32'h0040_0000; end
                default: begin got = target_pc ^ {30'd0, req, eret}; want = VEC ^ 32'd2; end
            endcase
            n_vec++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL eret step %0d: got %h want %h", s, got, want);
            end
            advance();
        end
    endtask

    task automatic test_mtc0_drop();
        logic [31:0] got, want;
        do_reset();
        mtc0(5'd12, 32'h0000_FF01);
        for (int s = 0; s < 5; s++) begin
            idle();
            case (s)
                0: begin we = 1'b1; addr = 5'd12; wdata = 32'd0; ExcCode_M = 5'd8; valid_M = 1'b1; end
                1: addr = 5'd12;
                2: begin reset = 1'b1; ExcCode_M = 5'd12; valid_M = 1'b1; we = 1'b1;
                         addr = 5'd14; wdata = 32'h1111_1111; end
                3: addr = 5'd12;
                default: addr = 5'd14;
            endcase
            settle();
            n_vec++;
            if ({req, eret, target_pc, rdata} !== {exp_req, exp_eret, exp_tpc, exp_rdata}) begin
                n_bad++;
                $display("FAIL drop_model: got req=%b eret=%b tpc=%h rd=%h want %b %b %h %h",
                         req, eret, target_pc, rdata, exp_req, exp_eret, exp_tpc, exp_rdata);
            end
            case (s)
                0, 2: begin got = 32'(req); want = 32'd1; end
                1: begin got = rdata; want = 32'h0040_FF03; end
                3: begin got = rdata; want = 32'h0040_0000; end
                default: begin got = rdata; want = 32'd0; end
            endcase
            n_vec++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL mtc0_drop step %0d: got %h want %h", s, got, want);
            end
            advance();
        end
    endtask

    task automatic test_random();
        logic [4:0] codes [6] = '{5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd12};
        logic [4:0] regs  [8] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd31};
        do_reset();
        for (int i = 0; i < 600; i++) begin
            reset     = ($urandom_range(0, 63) == 0);
            ExcCode_M = ($urandom_range(0, 7) == 0) ? codes[$urandom_range(0, 5)] : 5'd0;
            valid_M   = ($urandom_range(0, 3) != 0);
            pc_M      = $urandom;
            bd_M      = 1'($urandom_range(0, 1));
            vaddr_M   = $urandom;
            eret_M    = ($urandom_range(0, 7) == 0);
            hw_int    = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
            we        = ($urandom_range(0, 2) == 0);
            addr      = regs[$urandom_range(0, 7)];
            wdata     = (addr == 5'd9 || addr == 5'd11) ? 32'($urandom_range(0, 24)) : $urandom;
            settle();
            n_vec++;
            if ({req, eret, target_pc, rdata} !== {exp_req, exp_eret, exp_tpc, exp_rdata}) begin
                n_bad++;
                $display("FAIL random cyc %0d: got req=%b eret=%b tpc=%h rd=%h want %b %b %h %h", i,
                         req, eret, target_pc, rdata, exp_req, exp_eret, exp_tpc, exp_rdata);
            end
            advance();
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_exception();
        test_adel_nested();
        test_interrupt();
        test_timer();
        test_count_wrap();
        test_eret();
        test_mtc0_drop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
